// File: rtl/mult_sequencer.sv
// Iterative radix-2 shift-add multiplier that borrows the shared N-bit ALU via alu_req/alu_gnt.
// Define MULT_SIGNED_EN to add the signed_op port and the two's-complement FIX cycle.
module mult_sequencer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef MULT_SIGNED_EN
  input  logic         signed_op,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         alu_req,
  input  logic         alu_gnt,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [4:0]   alu_fn,
  input  logic [N-1:0] alu_r
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

`ifdef MULT_SIGNED_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2, FIX = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic [N-1:0]    mcand_q, mcand_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
  logic [CW-1:0]   count_q, count_d;
  logic            carry;
  logic [2*N:0]    shifted;
`ifdef MULT_SIGNED_EN
  logic            neg_q, neg_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
`ifdef MULT_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
`ifdef MULT_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    carry   = 1'b0;
    shifted = '0;
`ifdef MULT_SIGNED_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = '0;
          state_d = RUN;
`ifdef MULT_SIGNED_EN
          neg_d   = 1'b0;
          if (signed_op) begin
            mcand_d = a[N-1] ? -a : a;
            lo_d    = b[N-1] ? -b : b;
            neg_d   = a[N-1] ^ b[N-1];
          end
`endif
        end
      end
      RUN: begin
        if (alu_gnt) begin
          // A wrapped ALU sum is smaller than hi; that is the lost carry-out bit.
          if (lo_q[0]) begin
            carry   = (alu_r < hi_q);
            shifted = {carry, alu_r, lo_q} >> 1;
          end else begin
            shifted = {1'b0, hi_q, lo_q} >> 1;
          end
          {hi_d, lo_d} = shifted[2*N-1:0];
          count_d      = count_q + CW'(1);
          if (count_q == LAST) begin
`ifdef MULT_SIGNED_EN
            state_d = neg_q ? FIX : DONE;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef MULT_SIGNED_EN
      FIX: begin
        {hi_d, lo_d} = -{hi_q, lo_q};
        state_d      = DONE;
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    alu_req = (state_q == RUN);
    alu_a   = (state_q == RUN) ? hi_q : '0;
    alu_b   = (state_q == RUN) ? mcand_q : '0;
    alu_fn  = 5'b00001;
    hi      = hi_q;
    lo      = lo_q;
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer (N=32); the bench models the shared ALU as an adder.
// Signed scenarios are compiled only when MULT_SIGNED_EN is defined.
module tb_mult_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        signed_op;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_fn;
  logic [31:0] alu_r;

  int vectors;
  int miscompares;

  mult_sequencer #(.N(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
`ifdef MULT_SIGNED_EN
    .signed_op (signed_op),
`endif
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .alu_req   (alu_req),
    .alu_gnt   (alu_gnt),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fn    (alu_fn),
    .alu_r     (alu_r)
  );

  // Shared ALU model: unsigned add, combinational
  assign alu_r = alu_a + alu_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one operation. Latency is reported as the accept edge to the edge that ends the done cycle.
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input logic sop,
                       input int s0, input int s1, input int s2, input bit poke,
                       output int lat, output int ndone, output bit fn_bad,
                       output logic [31:0] hi_at_done, output logic [31:0] lo_at_done);
    lat = 0;
    ndone = 0;
    fn_bad = 1'b0;
    hi_at_done = '0;
    lo_at_done = '0;
    a = av;
    b = bv;
    signed_op = sop;
    start = 1'b1;
    alu_gnt = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      alu_gnt = !(k == s0 || k == s1 || k == s2);
      start = poke && (k % 4 == 0) && (k <= 24);
      @(posedge clk); #1;
      if (alu_req === 1'b1 && alu_fn !== 5'b00001) fn_bad = 1'b1;
      if (done === 1'b1) begin
        ndone++;
        if (lat == 0) begin
          lat = k + 1;
          hi_at_done = hi;
          lo_at_done = lo;
        end
      end
    end
    start = 1'b0;
    alu_gnt = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    signed_op = 1'b0;
    alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (busy !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    vectors++; if (done !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_done got %b exp 0", done); end
    vectors++; if (hi !== 32'h0)    begin miscompares++; $display("[TB] FAIL reset_hi got %h exp 0", hi); end
    vectors++; if (lo !== 32'h0)    begin miscompares++; $display("[TB] FAIL reset_lo got %h exp 0", lo); end
    vectors++; if (alu_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_alu_req got %b exp 0", alu_req); end
    vectors++; if (alu_a !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_alu_a got %h exp 0", alu_a); end
    vectors++; if (alu_b !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_alu_b got %h exp 0", alu_b); end
    vectors++; if (alu_fn !== 5'b00001) begin miscompares++; $display("[TB] FAIL reset_alu_fn got %b exp 00001", alu_fn); end
  endtask

  task automatic test_unsigned_max;
    int lat, nd;
    bit fb;
    logic [31:0] hd, ld;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0, 0, 1'b0, lat, nd, fb, hd, ld);
    vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL max_latency got %0d exp 33", lat); end
    vectors++; if (hd !== 32'hFFFF_FFFE) begin miscompares++; $display("[TB] FAIL max_hi_at_done got %h exp fffffffe", hd); end
    vectors++; if (ld !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL max_lo_at_done got %h exp 00000001", ld); end
    vectors++; if (hi !== 32'hFFFF_FFFE) begin miscompares++; $display("[TB] FAIL max_hi_hold got %h exp fffffffe", hi); end
    vectors++; if (lo !== 32'h0000_0001) begin miscompares++; $display("[TB] FAIL max_lo_hold got %h exp 00000001", lo); end
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL max_done_count got %0d exp 1", nd); end
  endtask

  task automatic test_grant_stall;
    int lat, nd;
    bit fb;
    logic [31:0] hd, ld;
    do_op(32'd7, 32'd6, 1'b0, 3, 10, 20, 1'b0, lat, nd, fb, hd, ld);
    vectors++; if (lat !== 36) begin miscompares++; $display("[TB] FAIL stall_latency got %0d exp 36", lat); end
    vectors++; if (hd !== 32'd0) begin miscompares++; $display("[TB] FAIL stall_hi got %h exp 0", hd); end
    vectors++; if (ld !== 32'd42) begin miscompares++; $display("[TB] FAIL stall_lo got %0d exp 42", ld); end
    vectors++; if (fb !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_alu_fn got bad=%b exp bad=0", fb); end
  endtask

  task automatic test_zero_operand;
    int lat, nd;
    bit fb;
    logic [31:0] hd, ld;
    do_op(32'h0, 32'h1234_5678, 1'b0, 0, 0, 0, 1'b1, lat, nd, fb, hd, ld);
    vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL zero_latency got %0d exp 33", lat); end
    vectors++; if (hd !== 32'h0) begin miscompares++; $display("[TB] FAIL zero_hi got %h exp 0", hd); end
    vectors++; if (ld !== 32'h0) begin miscompares++; $display("[TB] FAIL zero_lo got %h exp 0", ld); end
    vectors++; if (nd !== 1) begin miscompares++; $display("[TB] FAIL zero_done_count got %0d exp 1", nd); end
  endtask

  task automatic test_abort;
    int nd;
    a = 32'h0000_1234;
    b = 32'h0000_FFFF;
    signed_op = 1'b0;
    alu_gnt = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++; if (busy !== 1'b0)    begin miscompares++; $display("[TB] FAIL abort_busy got %b exp 0", busy); end
    vectors++; if (alu_req !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_alu_req got %b exp 0", alu_req); end
    vectors++; if (hi !== 32'h0)     begin miscompares++; $display("[TB] FAIL abort_hi got %h exp 0", hi); end
    vectors++; if (lo !== 32'h0)     begin miscompares++; $display("[TB] FAIL abort_lo got %h exp 0", lo); end
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) nd++;
      @(posedge clk); #1;
    end
    vectors++; if (nd !== 0) begin miscompares++; $display("[TB] FAIL abort_done_count got %0d exp 0", nd); end
  endtask

  task automatic test_back_to_back;
    int k;
    a = 32'd3;
    b = 32'd4;
    signed_op = 1'b0;
    alu_gnt = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (done !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_first_done got %b exp 1", done); end
    vectors++; if (lo !== 32'd12) begin miscompares++; $display("[TB] FAIL b2b_first_lo got %0d exp 12", lo); end
    @(posedge clk); #1;
    a = 32'd10;
    b = 32'd11;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_accept_busy got %b exp 1", busy); end
    k = 0;
    while (done !== 1'b1 && k < 100) begin @(posedge clk); #1; k++; end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_second_done got %b exp 1", done); end
    vectors++; if (lo !== 32'd110) begin miscompares++; $display("[TB] FAIL b2b_second_lo got %0d exp 110", lo); end
    vectors++; if (hi !== 32'd0) begin miscompares++; $display("[TB] FAIL b2b_second_hi got %h exp 0", hi); end
    repeat (2) @(posedge clk);
    #1;
  endtask

`ifdef MULT_SIGNED_EN
  task automatic test_signed;
    int lat, nd;
    bit fb;
    logic [31:0] hd, ld;
    do_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, 0, 0, 1'b0, lat, nd, fb, hd, ld);
    vectors++; if (lat !== 34) begin miscompares++; $display("[TB] FAIL signed_neg_latency got %0d exp 34", lat); end
    vectors++; if (hd !== 32'hFFFF_FFFF) begin miscompares++; $display("[TB] FAIL signed_neg_hi got %h exp ffffffff", hd); end
    vectors++; if (ld !== 32'hFFFF_FFF1) begin miscompares++; $display("[TB] FAIL signed_neg_lo got %h exp fffffff1", ld); end
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0, 0, 1'b0, lat, nd, fb, hd, ld);
    vectors++; if (lat !== 33) begin miscompares++; $display("[TB] FAIL signed_min_latency got %0d exp 33", lat); end
    vectors++; if (hd !== 32'h4000_0000) begin miscompares++; $display("[TB] FAIL signed_min_hi got %h exp 40000000", hd); end
    vectors++; if (ld !== 32'h0) begin miscompares++; $display("[TB] FAIL signed_min_lo got %h exp 0", ld); end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset;
    test_unsigned_max;
    test_grant_stall;
    test_zero_operand;
    test_abort;
    test_back_to_back;
`ifdef MULT_SIGNED_EN
    test_signed;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Iterative radix-2 shift-add multiplier controller that borrows the processor's shared N-bit ALU to compute a 2N-bit product over N iterations. It sits beside the execute stage and arbitrates for the ALU with the datapath through a req/gnt pair. While it holds the ALU, it drives the ALU operands and function code. It returns {hi, lo} for MIPS-style MULTU/MULT.

## Interface
- N, 32, operand width; the ALU it drives is N bits wide
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- start  input  1  request a multiply; sampled only in IDLE
- a  input  N  multiplicand, captured on accepted start
- b  input  N  multiplier, captured on accepted start
- signed_op  input  1  two's-complement operands (present only with MULT_SIGNED_EN)
- busy  output  1  high from the cycle after accept until the done cycle inclusive
- done  output  1  one-cycle pulse; hi/lo valid from this cycle onward
- hi  output  N  upper product word; holds until the next accept
- lo  output  N  lower product word; holds until the next accept
- alu_req  output  1  ALU ownership request
- alu_gnt  input  1  datapath grants the ALU this cycle
- alu_a  output  N  ALU operand A
- alu_b  output  N  ALU operand B
- alu_fn  output  5  ALU function code; constant 5'b00001 (unsigned add)
- alu_r  input  N  ALU result, combinational in the same cycle

## Operation
- States: IDLE, RUN, FIX (only with MULT_SIGNED_EN), DONE.
- IDLE: start=1 accepts the operation.
  - Registers: mcand<=a, lo<=b, hi<=0, count<=0.
  - Next state is RUN.
  - start while not IDLE is ignored.
- RUN:
  - Outputs: alu_req=1, alu_a=hi, alu_b=mcand.
  - On a cycle with alu_gnt=1:
    - If lo[0]=1, carry = (alu_r < hi) as an unsigned compare, and {hi,lo} <= {carry, alu_r, lo[N-1:1]}.
    - Otherwise {hi,lo} <= {1'b0, hi, lo[N-1:1]}.
    - count increments.
  - On a cycle with alu_gnt=0: no register changes (stall).
  - After the iteration with count=N-1 completes, go to DONE, or to FIX when a sign fix-up is needed.
- DONE: done=1 and busy=1 for one cycle, then IDLE.
- alu_req=0, alu_a=0 and alu_b=0 outside RUN. alu_fn is always 5'b00001.
- Arithmetic:
  - Unsigned product, exact, 2N bits.
  - N=1 is legal (one iteration).
  - a=0 or b=0 gives a zero product and still takes the full N iterations.
- Reset mid-operation:
  - Abort to IDLE.
  - busy, done and alu_req go low.
  - hi and lo clear; no done pulse for the aborted operation.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, alu_req=0, alu_a=0, alu_b=0, state=IDLE.
- Accept at edge t. RUN spans edges t+1..t+N with continuous grant. done is high in the cycle after edge t+N; unsigned latency is N+1 cycles from the accept edge.
- Each cycle with alu_gnt=0 during RUN adds exactly one cycle of latency.
- alu_gnt is ignored outside RUN.
- The earliest back-to-back restart is the cycle after done: start high in the cycle after done is accepted.
- hi and lo change only on the accept edge, on RUN iterations, in FIX, or on reset. They are stable in and after done.

## Configuration
- MULT_SIGNED_EN defined:
  - The signed_op port exists.
  - On accept with signed_op=1, mcand and lo load |a| and |b|, and neg = a[N-1]^b[N-1] is stored.
  - If neg=1, after RUN comes one FIX cycle that does not use the ALU: {hi,lo} <= -{hi,lo} as a 2N-bit negation. DONE follows, so signed negative-result latency is N+2.
  - signed_op=0 behaves exactly as unsigned.
  - The most-negative operand -2^(N-1) is handled: its magnitude is 2^(N-1) unsigned.
- MULT_SIGNED_EN undefined: no signed_op port, no FIX state, unsigned only.

## Test plan
- Unsigned, N=32, grant held high: a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001.
- Grant stalls: a=7, b=6, alu_gnt low on 3 RUN cycles -> done 36 cycles after accept; hi=0, lo=42; alu_fn=5'b00001 throughout RUN.
- Zero operand: a=0, b=0x12345678 -> hi=0, lo=0 after the full N iterations; start pulses while busy are ignored, with no second done.
- Reset asserted at RUN iteration 10 -> next cycle state=IDLE, busy=0, alu_req=0, hi=lo=0, and no done pulse.
- With MULT_SIGNED_EN: signed_op=1, a=-3 (0xFFFFFFFD), b=5 -> done at N+2; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- With MULT_SIGNED_EN: a=0x80000000, b=0x80000000 signed -> hi=0x40000000, lo=0.
